// File: rtl/serial_comparator_ctrl_pkg.sv
// serial_comparator_ctrl_pkg: FSM state encoding and shared comparator result codes.
package serial_comparator_ctrl_pkg;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CMP  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    // Result codes packed as {g, l, eq}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;
endpackage

// File: rtl/comparator_1_bit.sv
// comparator_1_bit: combinational single-bit magnitude comparator.
module comparator_1_bit (
    input  logic a_in,
    input  logic b_in,
    output logic g_out,
    output logic l_out,
    output logic eq_out
);
    assign g_out  = a_in & ~b_in;
    assign l_out  = ~a_in & b_in;
    assign eq_out = ~(a_in ^ b_in);
endmodule

// File: rtl/serial_comparator_ctrl.sv
// serial_comparator_ctrl: MSB-first serial magnitude compare of two operands with early exit.
module serial_comparator_ctrl
    import serial_comparator_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             g_out,
    output logic             l_out,
    output logic             eq_out
);
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       res_q, res_d;
    logic             bit_g, bit_l, bit_eq, accept, in_cmp, last;

    comparator_1_bit u_bit (
        .a_in  (a_q[idx_q]),
        .b_in  (b_q[idx_q]),
        .g_out (bit_g),
        .l_out (bit_l),
        .eq_out(bit_eq)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // CMP never accepts, so a start during the sweep is simply dropped
    always_comb begin
        in_cmp  = state_q == ST_CMP;
        accept  = start_in && !in_cmp;
        last    = bit_g | bit_l | (bit_eq && idx_q == '0);
        state_d = accept ? ST_CMP : in_cmp ? (last ? ST_DONE : ST_CMP) : ST_IDLE;
    end

    always_comb begin
        a_d   = accept ? a_in : a_q;
        b_d   = accept ? b_in : b_q;
        idx_d = accept ? IDX_W'(WIDTH - 1) : (in_cmp && !last) ? idx_q - IDX_W'(1) : idx_q;
        res_d = accept ? RES_NONE : !in_cmp ? res_q : bit_g ? RES_GT : bit_l ? RES_LT :
                idx_q == '0 ? RES_EQ : res_q;
    end

    always_comb begin
        busy_out               = in_cmp;
        done_out               = state_q == ST_DONE;
        {g_out, l_out, eq_out} = res_q;
    end
endmodule
